// File: rtl/magnetron_sr_ctrl_pkg.sv
// Shared definitions for the magnetron s/r sequencer and the latch it drives.
package magnetron_sr_ctrl_pkg;

    // Sequencer states; the encoding is shared with the latch_sr tests.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSet   = 2'd1,
        StCook  = 2'd2,
        StClear = 2'd3
    } state_e;

    // Default clk cycles per cook-time tick.
    localparam int unsigned TickDivDefault = 100;

endpackage

// File: rtl/magnetron_tick.sv
// Cook-time prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module magnetron_tick
    import magnetron_sr_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TickDivDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CntW   = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: held at zero while cleared, wraps after the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/magnetron_sr_ctrl.sv
// Magnetron sequencer: drives s/r of the external SR latch, counts cook time
// down in prescaled ticks and never presents s and r together.
module magnetron_sr_ctrl
    import magnetron_sr_ctrl_pkg::*;
#(
    parameter int unsigned TIME_W   = 8,
    parameter int unsigned TICK_DIV = TickDivDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              door_closed_i,
    input  logic [TIME_W-1:0] time_load_i,
    input  logic              q_fb_i,
    output logic              s_o,
    output logic              r_o,
    output logic [TIME_W-1:0] remaining_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              done_q, done_d;
    logic              expired_q, expired_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic              start_q;
    logic              start_edge;
    logic              abort;
    logic              tick;

    assign start_edge = start_i & ~start_q;
    assign abort      = stop_i | ~door_closed_i;

    // Prescaler only runs in COOK, so it restarts from zero on every entry.
    magnetron_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != StCook),
        .tick_o (tick)
    );

    // Next-state, counter and registered-output decode; s_d and r_d are exclusive.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        expired_d = expired_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge && door_closed_i && (time_load_i != '0) && !stop_i) begin
                    state_d   = StSet;
                    rem_d     = time_load_i;
                    expired_d = 1'b0;
                    s_d       = 1'b1;
                end
            end
            StSet: begin
                if (abort) begin
                    state_d   = StClear;
                    expired_d = 1'b0;
                    r_d       = 1'b1;
                end else if (q_fb_i) begin
                    state_d = StCook;
                end else begin
                    s_d = 1'b1;
                end
            end
            StCook: begin
                // A latch that drops on its own is handled like an abort.
                if (abort || !q_fb_i) begin
                    state_d   = StClear;
                    expired_d = 1'b0;
                    r_d       = 1'b1;
                end else if (tick && (rem_q != '0)) begin
                    rem_d = rem_q - TIME_W'(1);
                    if (rem_q == TIME_W'(1)) begin
                        state_d   = StClear;
                        expired_d = 1'b1;
                        r_d       = 1'b1;
                    end
                end
            end
            StClear: begin
                if (!q_fb_i) begin
                    state_d = StIdle;
                    done_d  = expired_q;
                end else begin
                    r_d = 1'b1;
                end
            end
            default: begin
                state_d = StClear;
                r_d     = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the magnetron off and arms r.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StClear;
            s_q       <= 1'b0;
            r_q       <= 1'b1;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            rem_q     <= '0;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            expired_q <= expired_d;
            rem_q     <= rem_d;
            start_q   <= start_i;
        end
    end

    assign s_o         = s_q;
    assign r_o         = r_q;
    assign done_o      = done_q;
    assign remaining_o = rem_q;

endmodule

// File: doc/magnetron_sr_ctrl.md
Name: magnetron_sr_ctrl

Overview:
Control sequencer that drives the s/r inputs of the magnetron latch_sr and reads back its q.
- Turns the magnetron on when a valid start occurs: door closed and non-zero cook time.
- Counts the cook time down in ticks.
- Clears the latch on expiry, stop or door open.
- Never asserts s and r together, the latch's forbidden input combination.

Parameters:
TIME_W, 8, width of cook-time load value and remaining counter (units: ticks)
TICK_DIV, 100, clk cycles per cook-time tick; legal range 2..2^16

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  start button level; rising edge detected internally
stop  input  1  stop button level; level-sensitive
door_closed  input  1  1 = door closed interlock satisfied
time_load  input  TIME_W  cook time in ticks, sampled on accepted start
q_fb  input  1  q of latch_sr (magnetron on)
s  output  1  set to latch_sr, registered
r  output  1  reset to latch_sr, registered
remaining  output  TIME_W  ticks left, registered
done  output  1  one-cycle pulse on normal cook completion

Behaviour:
- Clock and reset: single clk domain. Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values (rst_n=0 on an edge):
  - state=CLEAR, s=0, r=1, remaining=0, done=0, expired=0
  - tick prescaler=0, start edge register=1, so a start held through reset is not taken as an edge.
  - Purpose: the magnetron is forced off after reset.
- States: IDLE, SET, COOK, CLEAR. All outputs registered; next-state decisions use inputs sampled at edge N, with outputs visible after edge N.
- IDLE: s=0, r=0.
  - start_edge & door_closed & time_load!=0 & !stop -> SET; remaining<=time_load, expired<=0.
  - Any other start is ignored and remaining is held.
- SET: s=1, r=0. Moves to COOK on the edge where q_fb=1 is sampled; s drops to 0 that same edge.
- Abort in SET or COOK: stop=1 or door_closed=0 -> CLEAR, expired<=0, remaining held. Abort has priority over every other transition and over the tick.
- COOK: s=0, r=0.
  - Prescaler counts 0..TICK_DIV-1 and is cleared on entry to COOK.
  - Tick = prescaler at TICK_DIV-1; on a tick, remaining decrements by 1.
  - The tick that takes remaining from 1 to 0 -> CLEAR with expired<=1.
  - remaining never wraps below 0.
- CLEAR: r=1, s=0. Moves to IDLE on the edge where q_fb=0 is sampled; r drops to 0 that same edge. done=1 for exactly that one cycle if expired=1.
- Invariant: s&r==0 on every cycle, including the cycle after reset.
- start held high across completion does not restart; a new rising edge is required.
- q_fb dropping to 0 spontaneously during COOK is treated as an abort (-> CLEAR, expired=0).

Decomposition:
- Shared package/include: state encoding localparams (IDLE=2'd0, SET=2'd1, COOK=2'd2, CLEAR=2'd3) and default TICK_DIV. latch_sr and its tests reuse the same include.
- Sub-module magnetron_tick: prescaler with clear input and one-cycle tick output, parameter TICK_DIV.
- Top module owns the FSM, the remaining counter and the start edge detector.
- Top-level bench instantiates magnetron_sr_ctrl connected to latch_sr, with q_fb=q.

Test Plan:
- Reset with start=1: rst_n=0 for 2 clk, then release with latch q=1 -> r=1 and s=0 in the first cycle; IDLE once q=0; no SET while start stays high.
- Normal cook (TICK_DIV=4): start edge, time_load=3, door_closed=1 -> s=1 for 1 cycle then q=1; remaining 3->2->1->0 every 4 clk; r=1; q=0; done pulses exactly once.
- Door opens after remaining=2 -> CLEAR within 1 clk, q=0, remaining stays 2, done=0.
- Stop in SET before q_fb rises -> s goes 0 and r goes 1 on the next edge; never s=r=1 (assertion across whole run).
- Rejected starts: door_closed=0, or time_load=0, or stop=1 at start edge -> state stays IDLE, s=0, remaining unchanged.
- Back-to-back: second start edge during COOK is ignored; start edge after done with time_load=1 -> new cook, done again after 1 tick.
